// File: rtl/cic_pkg.sv
// Shared helpers for the CIC integrator chain: width functions and parameter legality.
package cic_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int ch_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic bit params_ok(input int inp_w, input int out_w, input int acc_w,
                                   input int stages, input int channels, input int dec);
    return (acc_w >= inp_w) && (out_w <= acc_w) && (out_w >= 1) &&
           (stages >= 1) && (stages <= 8) &&
           (channels >= 1) && (channels <= 16) && (dec >= 1);
  endfunction

endpackage

// File: rtl/cic_integrator_chain_if.sv
// Sample bus of the integrator chain: input strobe/data towards the chain, tagged output back.
interface cic_integrator_chain_if #(
  parameter int DATA_WIDTH_INP = 8,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int CH_W           = 1
);
  logic signed [DATA_WIDTH_INP-1:0] inp_samp_data;
  logic                             inp_samp_str;
  logic signed [DATA_WIDTH_OUT-1:0] out_samp_data;
  logic                             out_samp_str;
  logic        [CH_W-1:0]           out_samp_ch;
  logic                             out_dec_str;

  modport master (
    output inp_samp_data, inp_samp_str,
    input  out_samp_data, out_samp_str, out_samp_ch, out_dec_str
  );

  modport slave (
    input  inp_samp_data, inp_samp_str,
    output out_samp_data, out_samp_str, out_samp_ch, out_dec_str
  );
endinterface

// File: rtl/integrator_stage_tdm.sv
// One registered integrator with a per-channel accumulator; 1 cycle latency.
// No backpressure: every upstream valid is absorbed and forwarded the next cycle.
module integrator_stage_tdm
  import cic_pkg::*;
#(
  parameter int ACC_WIDTH = 20,
  parameter int CHANNELS  = 1,
  parameter int CH_W      = ch_width(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 up_vld,
  input  logic [CH_W-1:0]      up_ch,
  input  logic                 up_dec,
  input  logic [ACC_WIDTH-1:0] up_dat,
  output logic                 dn_vld,
  output logic [CH_W-1:0]      dn_ch,
  output logic                 dn_dec,
  output logic [ACC_WIDTH-1:0] dn_dat
);

  logic [ACC_WIDTH-1:0] acc [CHANNELS];
  logic [ACC_WIDTH-1:0] sum;

  // Modulo 2^ACC_WIDTH add; wrap-around is what the downstream comb relies on.
  assign sum = acc[up_ch] + up_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      dn_vld <= 1'b0;
      dn_ch  <= '0;
      dn_dec <= 1'b0;
      dn_dat <= '0;
    end else if (clear) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      dn_vld <= 1'b0;
    end else begin
      dn_vld <= up_vld;
      if (up_vld) begin
        acc[up_ch] <= sum;
        dn_dat     <= sum;
        dn_ch      <= up_ch;
        dn_dec     <= up_dec;
      end
    end
  end

endmodule

// File: rtl/cic_integrator_chain.sv
// TDM cascade of STAGES integrators with channel/frame tagging; output STAGES cycles after input.
// No backpressure: one sample accepted per strobe, downstream must take every out_samp_str.
module cic_integrator_chain
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH_INP = 8,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int ACC_WIDTH      = 20,
  parameter int STAGES         = 3,
  parameter int CHANNELS       = 1,
  parameter int DECIMATION     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  cic_integrator_chain_if.slave  bus
);

  localparam int CH_W = ch_width(CHANNELS);
  localparam int FR_W = ch_width(DECIMATION);

  if (!params_ok(DATA_WIDTH_INP, DATA_WIDTH_OUT, ACC_WIDTH, STAGES, CHANNELS, DECIMATION))
  begin : g_bad_params
    $error("cic_integrator_chain: illegal parameter combination");
  end

  logic            accept;
  logic [CH_W-1:0] ch_cnt;
  logic [FR_W-1:0] frm_cnt;
  logic            ch_last;
  logic            frm_last;

  logic                 vld  [STAGES+1];
  logic [CH_W-1:0]      chs  [STAGES+1];
  logic                 decs [STAGES+1];
  logic [ACC_WIDTH-1:0] dats [STAGES+1];

  // clear wins over a sample presented in the same cycle.
  assign accept   = bus.inp_samp_str & ~clear;
  assign ch_last  = (ch_cnt == CH_W'(CHANNELS - 1));
  assign frm_last = (frm_cnt == FR_W'(DECIMATION - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_cnt  <= '0;
      frm_cnt <= '0;
    end else if (clear) begin
      ch_cnt  <= '0;
      frm_cnt <= '0;
    end else if (accept) begin
      ch_cnt <= ch_last ? '0 : ch_cnt + 1'b1;
      if (ch_last) frm_cnt <= frm_last ? '0 : frm_cnt + 1'b1;
    end
  end

  assign vld[0]  = accept;
  assign chs[0]  = ch_cnt;
  assign decs[0] = frm_last;
  assign dats[0] = ACC_WIDTH'(bus.inp_samp_data);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    integrator_stage_tdm #(
      .ACC_WIDTH (ACC_WIDTH),
      .CHANNELS  (CHANNELS),
      .CH_W      (CH_W)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .up_vld  (vld[k]),
      .up_ch   (chs[k]),
      .up_dec  (decs[k]),
      .up_dat  (dats[k]),
      .dn_vld  (vld[k+1]),
      .dn_ch   (chs[k+1]),
      .dn_dec  (decs[k+1]),
      .dn_dat  (dats[k+1])
    );
  end

  assign bus.out_samp_data = dats[STAGES][ACC_WIDTH-1 -: DATA_WIDTH_OUT];
  assign bus.out_samp_str  = vld[STAGES];
  assign bus.out_dec_str   = vld[STAGES] & decs[STAGES];

  if (CHANNELS == 1) begin : g_single_ch
    assign bus.out_samp_ch = '0;
  end else begin : g_multi_ch
    assign bus.out_samp_ch = chs[STAGES];
  end

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Random-stimulus bench for cic_integrator_chain against a closed-form per-channel CIC model.
module tb_cic_integrator_chain;

  localparam int INP_W = 8;
  localparam int OUT_W = 16;
  localparam int ACC_W = 20;
  localparam int NSTG  = 3;
  localparam int NCH   = 3;
  localparam int NDEC  = 4;
  localparam int CHW   = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic clear   = 1'b0;

  always #5 clk = ~clk;

  cic_integrator_chain_if #(
    .DATA_WIDTH_INP (INP_W),
    .DATA_WIDTH_OUT (OUT_W),
    .CH_W           (CHW)
  ) bus ();

  cic_integrator_chain #(
    .DATA_WIDTH_INP (INP_W),
    .DATA_WIDTH_OUT (OUT_W),
    .ACC_WIDTH      (ACC_W),
    .STAGES         (NSTG),
    .CHANNELS       (NCH),
    .DECIMATION     (NDEC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  typedef struct {
    bit     v;
    longint dat;
    longint ch;
    bit     dec;
  } exp_t;

  exp_t   dl [NSTG];
  longint hist [NCH][$];
  int     acc_cnt;
  longint last_dat;
  longint last_ch;

  // Weight of a sample m positions back in an NSTG-fold running sum: C(m+NSTG-1, NSTG-1).
  function automatic longint binom(input int m);
    longint c;
    c = 1;
    for (int i = 1; i < NSTG; i++) c = c * (m + i) / i;
    return c;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) hist[c].delete();
    acc_cnt = 0;
    for (int i = 0; i < NSTG; i++) dl[i].v = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    last_dat = 0;
    last_ch  = 0;
  endtask

  task automatic model_push(input longint x, output exp_t e);
    int     c;
    int     n;
    longint y;
    c = acc_cnt % NCH;
    hist[c].push_back(x);
    n = hist[c].size();
    y = 0;
    for (int j = 0; j < n; j++) y += binom(n - 1 - j) * hist[c][j];
    y = y & ((longint'(1) << ACC_W) - 1);
    y = y >> (ACC_W - OUT_W);
    if (y >= (longint'(1) << (OUT_W - 1))) y -= (longint'(1) << OUT_W);
    e.v   = 1'b1;
    e.dat = y;
    e.ch  = c;
    e.dec = (((acc_cnt / NCH) % NDEC) == NDEC - 1);
    acc_cnt++;
  endtask

  // One cycle: check outputs at the falling edge, then present the next input.
  task automatic step(input bit str, input logic signed [INP_W-1:0] d, input bit clr);
    exp_t e;
    exp_t n;
    @(negedge clk);
    e = dl[NSTG-1];
    if (e.v) begin
      last_dat = e.dat;
      last_ch  = e.ch;
    end
    check("out_samp_str",  bus.out_samp_str,  e.v);
    check("out_samp_data", bus.out_samp_data, last_dat);
    check("out_samp_ch",   bus.out_samp_ch,   last_ch);
    check("out_dec_str",   bus.out_dec_str,   (e.v && e.dec) ? 1 : 0);
    for (int i = NSTG - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0].v = 1'b0;
    bus.inp_samp_str  = str;
    bus.inp_samp_data = d;
    clear             = clr;
    if (clr) begin
      model_clear();
    end else if (str) begin
      model_push(longint'(d), n);
      dl[0] = n;
    end
  endtask

  // Asynchronous reset asserted between edges while a sample is being presented.
  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_str",  bus.out_samp_str,  0);
    check("rst_async_data", bus.out_samp_data, 0);
    check("rst_async_ch",   bus.out_samp_ch,   0);
    check("rst_async_dec",  bus.out_dec_str,   0);
    bus.inp_samp_str = 1'b0;
    clear            = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic signed [INP_W-1:0] d;
    bit                      s;
    bit                      c;
    bus.inp_samp_str  = 1'b0;
    bus.inp_samp_data = '0;
    model_reset();
    #1;
    check("reset_str",  bus.out_samp_str,  0);
    check("reset_data", bus.out_samp_data, 0);
    check("reset_ch",   bus.out_samp_ch,   0);
    check("reset_dec",  bus.out_dec_str,   0);
    @(negedge clk);
    reset_n = 1'b1;

    // Constant inputs on consecutive cycles, then full-scale positive to reach wrap quickly.
    for (int i = 0; i < 5; i++) step(1'b1, 8'sd1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'sd127, 1'b0);
    for (int i = 0; i < NSTG + 1; i++) step(1'b0, 8'sd0, 1'b0);

    // Clear together with a sample, then a fresh 5 after clear.
    for (int i = 0; i < 4; i++) step(1'b1, 8'sd3, 1'b0);
    step(1'b1, 8'sd7, 1'b1);
    for (int i = 0; i < NSTG; i++) step(1'b0, 8'sd0, 1'b0);
    step(1'b1, 8'sd5, 1'b0);
    for (int i = 0; i < NSTG + 1; i++) step(1'b0, 8'sd0, 1'b0);

    // Randomised stream with extremes, gaps and occasional clears; reset pulsed mid-stream.
    for (int i = 0; i < 700; i++) begin
      s = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0:       d = 8'sd127;
        1:       d = -8'sd128;
        default: d = INP_W'($urandom);
      endcase
      c = ($urandom_range(0, 59) == 0);
      step(s, d, c);
      if (i == 350) pulse_reset();
    end
    for (int i = 0; i < NSTG + 2; i++) step(1'b0, 8'sd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_integrator_chain.md
Name: cic_integrator_chain

Overview:
Cascade of STAGES pipelined integrators for the CIC decimator front end. The channels are time-multiplexed round-robin on one input bus. Each stage keeps per-channel accumulator state. The last stage output is MSB-truncated, and the output carries a decimation flag that marks every DECIMATION-th frame for the downstream comb section.

Parameters:
DATA_WIDTH_INP, 8, signed input sample width
DATA_WIDTH_OUT, 16, signed output width; taken from accumulator MSBs; must be <= ACC_WIDTH
ACC_WIDTH, 20, internal accumulator width; must be >= DATA_WIDTH_INP; sized by user as DATA_WIDTH_INP + STAGES*clog2(DECIMATION)
STAGES, 3, number of cascaded integrators (1..8)
CHANNELS, 1, number of TDM channels (1..16)
DECIMATION, 4, frames per decimated output (>= 1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of all state
inp_samp_data  input  DATA_WIDTH_INP  signed sample; channel order 0,1,..,CHANNELS-1 repeating
inp_samp_str  input  1  sample valid strobe; may be high on consecutive cycles
out_samp_data  output  DATA_WIDTH_OUT  acc_last[ACC_WIDTH-1 -: DATA_WIDTH_OUT]
out_samp_str  output  1  output valid, one cycle per accepted input
out_samp_ch  output  CH_W  channel tag of the output sample; CH_W = max(1, clog2(CHANNELS))
out_dec_str  output  1  high with out_samp_str when the sample belongs to the decimated frame

Behaviour:
- Reset (reset_n low, asynchronous): all accumulators = 0, channel counter = 0, frame counter = 0, pipeline valids = 0. Outputs: out_samp_data = 0, out_samp_str = 0, out_samp_ch = 0, out_dec_str = 0. A reset mid-stream discards all in-flight samples.
- Input tagging: an internal channel counter tags each accepted sample (inp_samp_str = 1) and then increments, wrapping CHANNELS-1 -> 0. A frame counter increments when the channel counter wraps, wrapping DECIMATION-1 -> 0. The dec flag is set when the frame counter is DECIMATION-1.
- Stage k (0-based) is registered. On valid input with tag c: acc_k[c] <= acc_k[c] + x_k, where:
  - x_0 is inp_samp_data sign-extended to ACC_WIDTH;
  - x_k for k > 0 is the new acc_{k-1}[c] value registered by stage k-1.
- Valid, channel tag and dec flag travel with the data through the stages. Channels that are not addressed hold their state.
- Arithmetic is two's complement modulo 2^ACC_WIDTH. Wrap-around is required, so no saturation and no overflow flag.
- Latency: the out_samp_* outputs are valid exactly STAGES cycles after the accepting clk edge. Throughput is one sample per cycle.
- Output data, channel and dec flag hold their last value while out_samp_str is low. out_dec_str is never high without out_samp_str.
- clear high at an edge:
  - zeroes all accumulators and both counters;
  - drops in-flight valids, so out_samp_str stays low for the next STAGES cycles unless new samples are accepted;
  - a sample presented in the same cycle as clear is discarded (clear wins).
- CHANNELS = 1: the channel counter is constant 0 and out_samp_ch is tied to 0. DECIMATION = 1: dec flag is always 1.
- No backpressure. The downstream block must accept every out_samp_str.

Decomposition:
- Package cic_pkg:
  - function clog2;
  - ch_width function returning max(1, clog2(n));
  - parameter legality checks (ACC_WIDTH >= DATA_WIDTH_INP, DATA_WIDTH_OUT <= ACC_WIDTH, STAGES/CHANNELS ranges), implemented as elaboration-time assertions.
- Sub-module integrator_stage_tdm:
  - one stage with CHANNELS-deep accumulator array;
  - ports: valid/ch/dec/data in and out, clear;
  - instantiated STAGES times in a generate loop.
- The top level holds the channel/frame counters and the output truncation.

Test Plan:
- STAGES=1, CHANNELS=1, input 1 on 5 consecutive cycles -> outputs (ACC=OUT width) 1,2,3,4,5, each 1 cycle after its input.
- STAGES=2, CHANNELS=1, input 1 x5 -> outputs 1,3,6,10,15 with 2-cycle latency. STAGES=3 -> 1,4,10,20,35 with 3-cycle latency.
- Wrap: STAGES=1, ACC_WIDTH=DATA_WIDTH_OUT=8, input 127 x3 -> outputs 127, -2, 125.
- TDM isolation and decimation flag:
  - setup: CHANNELS=2, STAGES=1, DECIMATION=2, inputs alternating ch0 = 3, ch1 = -1 for 4 frames;
  - ch0 outputs 3,6,9,12 and ch1 outputs -1,-2,-3,-4, with out_samp_ch alternating 0,1;
  - out_dec_str is high only on frames 1 and 3 (0-based).
- clear and reset:
  - clear mid-stream with a sample in the same cycle -> that sample is dropped, no out_samp_str for STAGES cycles, and the next input 5 gives output 5 (STAGES=1);
  - reset_n pulsed low between clock edges -> outputs 0 immediately, and the next stream restarts on channel 0 and frame 0.
